// File: rtl/axi_pattern_master.sv
// AXI3 single-burst pattern writer/checker, programmed over APB4.
// Ports: i_aclk/i_aresetn, AXI3 AW/W/B/AR/R master, APB4 slave, o_irq.
module axi_pattern_master #(
  parameter int DATA_W = 128,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic                i_aclk,
  input  logic                i_aresetn,
  output logic                o_irq,
  output logic [ID_W-1:0]     o_awid,
  output logic [ADDR_W-1:0]   o_awaddr,
  output logic [3:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic [1:0]          o_awlock,
  output logic [3:0]          o_awcache,
  output logic [2:0]          o_awprot,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [ID_W-1:0]     o_wid,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_W-1:0]     i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ID_W-1:0]     o_arid,
  output logic [ADDR_W-1:0]   o_araddr,
  output logic [3:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic [1:0]          o_arlock,
  output logic [3:0]          o_arcache,
  output logic [2:0]          o_arprot,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_W-1:0]     i_rid,
  input  logic [DATA_W-1:0]   i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready,
  input  logic                i_psel,
  input  logic                i_penable,
  input  logic [31:0]         i_paddr,
  input  logic                i_pwrite,
  input  logic [31:0]         i_pwdata,
  input  logic [2:0]          i_pprot,
  input  logic [3:0]          i_pstrb,
  output logic [31:0]         o_prdata,
  output logic                o_pready,
  output logic                o_pslverr
);
  localparam int BYTES = DATA_W / 8;
  localparam int LANES = DATA_W / 32;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic        mode_q, irqen_q;
  logic [31:0] addr_q, seed_q, miscnt_q;
  logic [3:0]  len_q;
  // {last_err, mismatch, cfg_err, resp_err, done}
  logic [4:0]  sts_q, sts_set;
  logic        cnt_inc;

  logic [7:0]  off;
  logic        acc, busy, mapped, cfg_reg;
  logic        wr_ok, start, cfg_bad, rd_bad;
  logic [4:0]  w1c;
  logic [31:0] pat, bound;
  logic        unused_ok;

  assign unused_ok = ^{i_paddr[31:8], i_pprot, i_pstrb, i_bid, i_rid};

  assign off     = i_paddr[7:0];
  assign acc     = i_psel & i_penable;
  assign busy    = state_q inside {S_AW, S_W, S_B, S_AR, S_R};
  assign mapped  = off inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
  assign cfg_reg = off inside {8'h00, 8'h04, 8'h08, 8'h0C};

  assign o_pready  = 1'b1;
  assign o_pslverr = acc & (~mapped | (i_pwrite & busy & cfg_reg));
  assign wr_ok     = acc & i_pwrite & ~o_pslverr;
  assign start     = wr_ok & (off == 8'h00) & i_pwdata[0];
  assign w1c       = (wr_ok && off == 8'h10) ? i_pwdata[5:1] : 5'd0;

  always_comb begin
    o_prdata = 32'd0;
    if (acc) begin
      unique case (1'b1)
        off == 8'h00: o_prdata = {29'd0, irqen_q, mode_q, 1'b0};
        off == 8'h04: o_prdata = addr_q;
        off == 8'h08: o_prdata = {28'd0, len_q};
        off == 8'h0C: o_prdata = seed_q;
        off == 8'h10: o_prdata = {26'd0, sts_q, busy};
        off == 8'h14: o_prdata = miscnt_q;
        default:      o_prdata = 32'd0;
      endcase
    end
  end

  // End address of the burst within its 4 KB page.
  assign bound   = {20'd0, addr_q[11:0]} + ((32'(len_q) + 32'd1) << SIZE);
  assign cfg_bad = (addr_q[SIZE-1:0] != '0) | (bound > 32'd4096);

  assign pat = seed_q + {28'd0, beat_q};

  always_comb begin
    rd_bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (i_rdata[i*32 +: 32] != pat) rd_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    sts_set = 5'd0;
    cnt_inc = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          if (cfg_bad) begin
            state_d = S_DONE;
            sts_set = 5'b00101;
          end else begin
            state_d = i_pwdata[1] ? S_AR : S_AW;
          end
        end
      end
      S_AW: begin
        if (i_awready) begin
          state_d = S_W;
          beat_d  = 4'd0;
        end
      end
      S_W: begin
        if (i_wready) begin
          if (beat_q == len_q) state_d = S_B;
          else beat_d = beat_q + 4'd1;
        end
      end
      S_B: begin
        if (i_bvalid) begin
          state_d    = S_DONE;
          sts_set[0] = 1'b1;
          sts_set[1] = i_bresp != 2'b00;
        end
      end
      S_AR: begin
        if (i_arready) begin
          state_d = S_R;
          beat_d  = 4'd0;
        end
      end
      S_R: begin
        if (i_rvalid) begin
          sts_set[1] = i_rresp != 2'b00;
          sts_set[3] = rd_bad;
          cnt_inc    = rd_bad;
          sts_set[4] = i_rlast != (beat_q == len_q);
          // A missing rlast still ends the burst after beat LEN.
          if (i_rlast || beat_q == len_q) begin
            state_d    = S_DONE;
            sts_set[0] = 1'b1;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      state_q  <= S_IDLE;
      beat_q   <= 4'd0;
      mode_q   <= 1'b0;
      irqen_q  <= 1'b0;
      addr_q   <= 32'd0;
      len_q    <= 4'd0;
      seed_q   <= 32'd0;
      sts_q    <= 5'd0;
      miscnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (wr_ok && off == 8'h00) begin
        mode_q  <= i_pwdata[1];
        irqen_q <= i_pwdata[2];
      end
      if (wr_ok && off == 8'h04) addr_q <= i_pwdata;
      if (wr_ok && off == 8'h08) len_q  <= i_pwdata[3:0];
      if (wr_ok && off == 8'h0C) seed_q <= i_pwdata;
      // Hardware set beats a same-cycle software clear.
      sts_q <= sts_set | (sts_q & ~w1c);
      if (start) miscnt_q <= 32'd0;
      else if (cnt_inc && miscnt_q != 32'hFFFF_FFFF)
        miscnt_q <= miscnt_q + 32'd1;
    end
  end

  assign o_irq = sts_q[0] & irqen_q;

  assign o_awid    = '0;
  assign o_awaddr  = ADDR_W'(addr_q);
  assign o_awlen   = len_q;
  assign o_awsize  = 3'(SIZE);
  assign o_awburst = 2'b01;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'b0011;
  assign o_awprot  = 3'b000;
  assign o_awvalid = state_q == S_AW;

  assign o_wid    = '0;
  assign o_wdata  = {LANES{pat}};
  assign o_wstrb  = '1;
  assign o_wlast  = beat_q == len_q;
  assign o_wvalid = state_q == S_W;
  assign o_bready = state_q == S_B;

  assign o_arid    = '0;
  assign o_araddr  = ADDR_W'(addr_q);
  assign o_arlen   = len_q;
  assign o_arsize  = 3'(SIZE);
  assign o_arburst = 2'b01;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'b0011;
  assign o_arprot  = 3'b000;
  assign o_arvalid = state_q == S_AR;
  assign o_rready  = state_q == S_R;

endmodule
